// File: rtl/load_store_unit_if.sv
// Request/response, status and memory-side signals of load_store_unit.
// slave = the LSU itself; master = the execute stage plus data memory facing it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  logic [63:0] mem_address;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_address, mem_wdata, mem_write, mem_read
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_address, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store front end to a 64-bit doubleword memory; sub-doubleword stores use read-modify-write.
// Latency load/SD 2, SB/SH/SW 3, error 1; one request in flight, no response backpressure; LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [63:0] old_q;

  logic        resp_valid_q;
  logic        resp_err_q;
  logic [63:0] resp_rdata_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_bad;
  logic        req_full_store;

  logic [5:0]  q_shift;
  logic [63:0] q_mask;
  logic [63:0] lane_mask;
  logic [63:0] merged;
  logic [63:0] load_field;
  logic [63:0] load_result;

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Natural alignment: clear the low offset bits that the access size covers.
  function automatic logic [2:0] align_off(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      2'd0:    align_off = off;
      2'd1:    align_off = {off[2:1], 1'b0};
      2'd2:    align_off = {off[2], 2'b00};
      default: align_off = 3'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------- request decode
  assign accept         = bus.req_valid && (state == IDLE);
  assign req_illegal    = bus.req_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'd7);
  assign req_misaligned = (bus.req_addr[2:0] != align_off(bus.req_addr[2:0], bus.req_funct3[1:0]));
  assign req_full_store = bus.req_store && (bus.req_funct3[1:0] == 2'd3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_bad = req_illegal || req_misaligned;
`else
  assign req_bad = req_illegal;
`endif

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad) begin
            state_next = RESP;
          end else if (req_full_store) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = store_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    bus.req_ready   = (state == IDLE);
    bus.busy        = (state != IDLE);
    bus.mem_read    = (state == RD);
    bus.mem_write   = (state == WR);
    bus.mem_wdata   = (state == WR) ? merged : 64'h0;
    bus.mem_address = {3'b000, addr_q[63:3]};
    bus.resp_valid  = resp_valid_q;
    bus.resp_err    = resp_err_q;
    bus.resp_rdata  = resp_rdata_q;
  end

  // ---------------------------------------------------------------- datapath
  assign q_shift   = {align_off(addr_q[2:0], funct3_q[1:0]), 3'b000};
  assign q_mask    = size_mask(funct3_q[1:0]);
  assign lane_mask = q_mask << q_shift;

  always_comb begin
    merged = (old_q & ~lane_mask) | ((wdata_q & q_mask) << q_shift);
    if (funct3_q[1:0] == 2'd3) begin
      merged = wdata_q;
    end
  end

  // Loads resolve straight from the memory read port so the result lands in RESP.
  assign load_field = (bus.mem_rdata >> q_shift) & q_mask;

  always_comb begin
    case (funct3_q)
      3'd0:    load_result = {{56{load_field[7]}},  load_field[7:0]};
      3'd1:    load_result = {{48{load_field[15]}}, load_field[15:0]};
      3'd2:    load_result = {{32{load_field[31]}}, load_field[31:0]};
      default: load_result = load_field;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= 64'h0;
      wdata_q  <= 64'h0;
      funct3_q <= 3'd0;
      store_q  <= 1'b0;
      old_q    <= 64'h0;
    end else begin
      if (accept) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        funct3_q <= bus.req_funct3;
        store_q  <= bus.req_store;
      end
      if (state == RD) begin
        old_q <= bus.mem_rdata;
      end
    end
  end

  // Response registers hold non-zero values only while in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'h0;
    end else begin
      resp_valid_q <= (state_next == RESP);
      resp_err_q   <= (state == IDLE) && accept && req_bad;
      resp_rdata_q <= ((state == RD) && !store_q) ? load_result : 64'h0;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end between the execute stage and the 64-bit doubleword-indexed data memory. It accepts one RV64 load or store per request, converts the byte address to a doubleword index and byte offset, and performs the memory access. Loads get byte-lane extraction with sign or zero extension. Sub-doubleword stores use a read-modify-write sequence, so the memory only ever sees full 64-bit reads and writes.

## Interface
- No parameters (data width fixed at 64, address width fixed at 64).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request (high only in IDLE).
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV64 funct3: loads 0=LB 1=LH 2=LW 3=LD 4=LBU 5=LHU 6=LWU; stores 0=SB 1=SH 2=SW 3=SD.
- `req_addr`  in  64  byte address from ALU.
- `req_wdata`  in  64  store data (rs2), right-aligned.
- `resp_valid`  out  1  one-cycle pulse: request complete.
- `resp_rdata`  out  64  extended load result; 0 for stores and errors.
- `resp_err`  out  1  qualifies `resp_valid`: illegal funct3 or misaligned request.
- `busy`  out  1  high in every state except IDLE; core stalls on it.
- `mem_address`  out  64  doubleword index `{3'b0, addr[63:3]}`.
- `mem_wdata`  out  64  merged doubleword to the memory's `data_in`.
- `mem_write`  out  1  to `MemWrite`; memory commits at the rising edge that ends WR.
- `mem_read`  out  1  to `MemRead`.
- `mem_rdata`  in  64  memory `data_out`, valid combinationally while `mem_read` is high.

## Operation
- The request is latched on the accept edge (`req_valid && req_ready`): address, wdata, funct3, store. Inputs are ignored outside IDLE.
- States and transitions:
  - IDLE → RD: on accept of a load or a partial store (SB/SH/SW).
  - IDLE → WR: on accept of an SD.
  - IDLE → RESP: on accept of an illegal or misaligned request. No memory access occurs.
  - RD → RESP for a load; RD → WR for a partial store.
  - WR → RESP.
  - RESP → IDLE.
- RD: `mem_read`=1. `mem_rdata` is captured into the old-data register at the edge that leaves RD.
- WR: `mem_write`=1 and `mem_wdata` = merged data.
  - With offset `off`=addr[2:0], size mask M = 0xFF, 0xFFFF, 0xFFFF_FFFF or all-ones (SB/SH/SW/SD).
  - merged = (old & ~(M<<8·off)) | ((wdata & M) << 8·off).
  - For SD, merged = wdata.
- Little-endian: byte 0 is bits [7:0].
- Load result: field = (old >> 8·off) & M. LB/LH/LW are sign-extended from the field MSB; LBU/LHU/LWU/LD are zero-extended.
- Illegal: store funct3 > 3, or load funct3 = 7. Response is `resp_err`=1, `resp_rdata`=0.
- `mem_address` is driven from the latched address in every state. `mem_read` and `mem_write` are never high together.

## Timing
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_read`=0, `mem_write`=0, `mem_wdata`=0, `mem_address`=0.
- Latency from accept edge to `resp_valid` high:
  - Load: 2 cycles.
  - SD: 2 cycles.
  - SB/SH/SW: 3 cycles.
  - Error: 1 cycle.
- `resp_valid`, `resp_rdata` and `resp_err` are registered. They are valid only during RESP and return to 0 afterwards. There is no response backpressure.
- The next request can be accepted in the cycle after RESP.
- `mem_read` and `mem_write` are decoded from state and deassert immediately on reset assertion.
- Reset asserted during WR before the clock edge: no memory write occurs. Reset during RD: the load is dropped and no response is produced.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned requests (LH/LHU/SH with off[0]≠0, LW/LWU/SW with off[1:0]≠0, LD/SD with off≠0) go IDLE → RESP with `resp_err`=1 and no memory access.
- Not defined:
  - The offset is truncated to natural alignment (low bits cleared per size).
  - The access proceeds normally and `resp_err` is raised only for illegal funct3.

## Test plan
- Reset mid-flight: assert `rst_n`=0 during WR of an SB → memory word unchanged, all outputs return to reset values, `req_ready`=1.
- SD then LD: SD 0x1122334455667788 at addr 0x40 → `mem_address`=8 and `mem_write` for exactly one cycle. LD at 0x40 → `resp_rdata`=0x1122334455667788, `resp_valid` 2 cycles after accept.
- Partial store: SB 0xAB to addr 0x43 over word 0x1122334455667788 → memory word becomes 0x11223344AB667788; RD, WR and RESP are each visited once.
- Load extension: with word 0x00000000_80FF0000 at addr 0, LB at addr 2 → 0xFFFFFFFFFFFFFFFF. LHU at addr 2 → 0x80FF. LW at addr 0 → 0xFFFFFFFF80FF0000.
- Misaligned access:
  - With `LSU_MISALIGN_TRAP_EN`: LW at 0x06 → `resp_err`=1 one cycle after accept, `mem_read` never asserted.
  - Without the macro: the same request reads byte offset 4.
- Illegal funct3 and busy handling: load funct3=7 → `resp_err`=1, `resp_rdata`=0. Holding `req_valid` high while busy → no second accept until the cycle after RESP.
